ddr3_init_sequencer: RTL and testbench

Executes the DDR3 reset/initialization instruction stream held in the controller's initialization ROM, one 32-bit entry at a time. It counts each entry's delay and drives the DDR3 command, control and address pins. It sits directly downstream of the ROM and feeds the PHY command path. It raises o_init_done once the last entry retires, handing the bus to the normal scheduler.

---
 rtl/ddr3_init_sequencer_if.sv | 43 ++++
 rtl/ddr3_init_sequencer.sv | 170 +++++++++++++++++
 tb/tb_ddr3_init_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ddr3_init_sequencer_if.sv
// ============================================================================
// ddr3_init_sequencer_if : ROM fetch + DDR3 init pin bundle | rev 1.0
// ============================================================================
`default_nettype none

interface ddr3_init_sequencer_if #(
  parameter int ROM_ADDR_BITS = 4,
  parameter int ROW_BITS      = 14,
  parameter int BA_BITS       = 3
);
  logic [ROM_ADDR_BITS-1:0] o_rom_addr;
  logic [31:0]              i_rom_data;
  logic                     o_ddr3_reset_n;
  logic                     o_ddr3_cke;
  logic [3:0]               o_ddr3_cmd;
  logic [BA_BITS-1:0]       o_ddr3_ba;
  logic [ROW_BITS-1:0]      o_ddr3_addr;
  logic                     o_init_done;

  modport master (
    output o_rom_addr,
    input  i_rom_data,
    output o_ddr3_reset_n,
    output o_ddr3_cke,
    output o_ddr3_cmd,
    output o_ddr3_ba,
    output o_ddr3_addr,
    output o_init_done
  );

  modport slave (
    input  o_rom_addr,
    output i_rom_data,
    input  o_ddr3_reset_n,
    input  o_ddr3_cke,
    input  o_ddr3_cmd,
    input  o_ddr3_ba,
    input  o_ddr3_addr,
    input  o_init_done
  );
endinterface

`default_nettype wire

// File: rtl/ddr3_init_sequencer.sv
// ============================================================================
// ddr3_init_sequencer : steps through the init ROM, timing each entry and
// driving DDR3 RESET#/CKE/command/address pins | rev 1.0
// ============================================================================
`default_nettype none

module ddr3_init_sequencer #(
  parameter int NUM_ENTRIES   = 16,
  parameter int ROM_ADDR_BITS = 4,
  parameter int ROW_BITS      = 14,
  parameter int BA_BITS       = 3
) (
  input  wire logic               i_clk,
  input  wire logic               i_rst_n,
  ddr3_init_sequencer_if.master   bus
);

  localparam logic [3:0]               c_cmd_nop      = 4'b0111;
  localparam logic [3:0]               c_cmd_deselect = 4'b1111;
  localparam logic [ROM_ADDR_BITS-1:0] c_last_addr    = ROM_ADDR_BITS'(NUM_ENTRIES - 1);

  generate
    if ((2 ** ROM_ADDR_BITS) < NUM_ENTRIES) begin : g_bad_rom_addr_bits
      $error("ROM_ADDR_BITS too small for NUM_ENTRIES");
    end
    if ((ROW_BITS > 16) || (BA_BITS != 3)) begin : g_bad_pin_widths
      $error("ROW_BITS must be <= 16 and BA_BITS must be 3");
    end
  endgenerate

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [18:0]              counter_q, counter_d;
  logic [ROM_ADDR_BITS-1:0] rom_addr_q, rom_addr_d;
  logic                     reset_n_q, reset_n_d;
  logic                     cke_q, cke_d;
  logic [3:0]               cmd_q, cmd_d;
  logic [BA_BITS-1:0]       ba_q, ba_d;
  logic [ROW_BITS-1:0]      addr_q, addr_d;
  logic                     done_q, done_d;
  logic                     stay_q, stay_d;
  logic                     last_q, last_d;

  // ROM entry fields
  logic        ent_use_timer;
  logic        ent_stay;
  logic        ent_cke;
  logic        ent_reset_n;
  logic [3:0]  ent_cmd;
  logic [18:0] ent_delay;
  logic        unused_rom_bits;

  assign ent_use_timer   = bus.i_rom_data[31];
  assign ent_stay        = bus.i_rom_data[30];
  assign ent_cke         = bus.i_rom_data[29];
  assign ent_reset_n     = bus.i_rom_data[28];
  assign ent_cmd         = bus.i_rom_data[27:24];
  assign ent_delay       = bus.i_rom_data[18:0];
  assign unused_rom_bits = ^bus.i_rom_data[23:19];

  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    rom_addr_d = rom_addr_q;
    reset_n_d  = reset_n_q;
    cke_d      = cke_q;
    cmd_d      = cmd_q;
    ba_d       = ba_q;
    addr_d     = addr_q;
    done_d     = done_q;
    stay_d     = stay_q;
    last_d     = last_q;

    case (state_q)
      FETCH: begin
        // Entry 0 is already presented; the first EXEC cycle sees counter 0 and loads it.
        state_d   = EXEC;
        counter_d = '0;
      end

      EXEC: begin
        if (counter_q != 19'd0) begin
          counter_d = counter_q - 19'd1;
          if (!stay_q) begin
            cmd_d = c_cmd_nop;
          end
        end else if (last_q) begin
          state_d = DONE;
          cmd_d   = c_cmd_nop;
          ba_d    = '0;
          addr_d  = '0;
          done_d  = 1'b1;
        end else begin
          reset_n_d = ent_reset_n;
          cke_d     = ent_cke;
          cmd_d     = ent_cmd;
          stay_d    = ent_stay;
          last_d    = (rom_addr_q == c_last_addr);
          if (rom_addr_q != c_last_addr) begin
            rom_addr_d = rom_addr_q + ROM_ADDR_BITS'(1);
          end
          if (ent_use_timer) begin
            ba_d      = '0;
            addr_d    = '0;
            counter_d = (ent_delay > 19'd1) ? (ent_delay - 19'd1) : 19'd0;
          end else begin
            ba_d      = bus.i_rom_data[16 +: BA_BITS];
            addr_d    = bus.i_rom_data[ROW_BITS-1:0];
            counter_d = '0;
          end
        end
      end

      DONE: begin
        cmd_d  = c_cmd_nop;
        ba_d   = '0;
        addr_d = '0;
        done_d = 1'b1;
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= FETCH;
      counter_q  <= '0;
      rom_addr_q <= '0;
      reset_n_q  <= 1'b0;
      cke_q      <= 1'b0;
      cmd_q      <= c_cmd_deselect;
      ba_q       <= '0;
      addr_q     <= '0;
      done_q     <= 1'b0;
      stay_q     <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      rom_addr_q <= rom_addr_d;
      reset_n_q  <= reset_n_d;
      cke_q      <= cke_d;
      cmd_q      <= cmd_d;
      ba_q       <= ba_d;
      addr_q     <= addr_d;
      done_q     <= done_d;
      stay_q     <= stay_d;
      last_q     <= last_d;
    end
  end

  assign bus.o_rom_addr     = rom_addr_q;
  assign bus.o_ddr3_reset_n = reset_n_q;
  assign bus.o_ddr3_cke     = cke_q;
  assign bus.o_ddr3_cmd     = cmd_q;
  assign bus.o_ddr3_ba      = ba_q;
  assign bus.o_ddr3_addr    = addr_q;
  assign bus.o_init_done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_ddr3_init_sequencer.sv
// ============================================================================
// tb_ddr3_init_sequencer : directed table-driven bench for ddr3_init_sequencer
// | rev 1.0
// ============================================================================
`default_nettype none

module tb_ddr3_init_sequencer;

  localparam int NUM_ENTRIES   = 16;
  localparam int ROM_ADDR_BITS = 4;
  localparam int ROW_BITS      = 14;
  localparam int BA_BITS       = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rom [NUM_ENTRIES];

  always #5 clk = ~clk;

  ddr3_init_sequencer_if #(
    .ROM_ADDR_BITS(ROM_ADDR_BITS),
    .ROW_BITS     (ROW_BITS),
    .BA_BITS      (BA_BITS)
  ) bus ();

  assign bus.i_rom_data = rom[bus.o_rom_addr];

  ddr3_init_sequencer #(
    .NUM_ENTRIES  (NUM_ENTRIES),
    .ROM_ADDR_BITS(ROM_ADDR_BITS),
    .ROW_BITS     (ROW_BITS),
    .BA_BITS      (BA_BITS)
  ) u_dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus.master)
  );

  typedef struct {
    logic [31:0] word;
    int          occ;
    logic        rn;
    logic        ck;
    logic [3:0]  cmd_first;
    logic [3:0]  cmd_rest;
    logic [2:0]  ba;
    logic [13:0] addr;
    logic [3:0]  raddr;
  } vec_t;

  vec_t vt [NUM_ENTRIES];
  int   n_checks = 0;
  int   n_fail   = 0;

  // {reset_n, cke, cmd, ba, addr, rom_addr, init_done}
  function automatic logic [27:0] pack(logic rn, logic ck, logic [3:0] cmd, logic [2:0] ba,
                                       logic [13:0] addr, logic [3:0] raddr, logic done);
    return {rn, ck, cmd, ba, addr, raddr, done};
  endfunction

  function automatic logic [27:0] actual();
    return pack(bus.o_ddr3_reset_n, bus.o_ddr3_cke, bus.o_ddr3_cmd, bus.o_ddr3_ba,
                bus.o_ddr3_addr, bus.o_rom_addr, bus.o_init_done);
  endfunction

  task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got rn/ck/cmd/ba/addr/raddr/done=%h required %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [31:0] word, input int occ, input logic rn,
                         input logic ck, input logic [3:0] cf, input logic [3:0] cr,
                         input logic [2:0] ba, input logic [13:0] addr, input logic [3:0] raddr);
    vt[i].word = word; vt[i].occ = occ; vt[i].rn = rn; vt[i].ck = ck;
    vt[i].cmd_first = cf; vt[i].cmd_rest = cr; vt[i].ba = ba; vt[i].addr = addr;
    vt[i].raddr = raddr;
  endtask

  // Edges from reset release until o_init_done is seen high; 0 on timeout.
  task automatic cycles_to_done(output int n);
    n = 0;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      if (bus.o_init_done === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  logic [27:0] reset_pins;
  logic [27:0] done_pins;
  int          lat;

  initial begin
    //       idx word          occ rn ck first    rest     ba    addr      raddr
    set_vec(0,  32'h87000005, 5, 0, 0, 4'b0111, 4'b0111, 3'd0, 14'h0000, 4'd1);
    set_vec(1,  32'h97000003, 3, 1, 0, 4'b0111, 4'b0111, 3'd0, 14'h0000, 4'd2);
    set_vec(2,  32'hB7000002, 2, 1, 1, 4'b0111, 4'b0111, 3'd0, 14'h0000, 4'd3);
    set_vec(3,  32'h30020018, 1, 1, 1, 4'b0000, 4'b0000, 3'd2, 14'h0018, 4'd4);
    set_vec(4,  32'h30F9C0A5, 1, 1, 1, 4'b0000, 4'b0000, 3'd1, 14'h00A5, 4'd5);
    set_vec(5,  32'hF6000004, 4, 1, 1, 4'b0110, 4'b0110, 3'd0, 14'h0000, 4'd6);
    set_vec(6,  32'hB6000004, 4, 1, 1, 4'b0110, 4'b0111, 3'd0, 14'h0000, 4'd7);
    set_vec(7,  32'hB7000000, 1, 1, 1, 4'b0111, 4'b0111, 3'd0, 14'h0000, 4'd8);
    set_vec(8,  32'hB7000001, 1, 1, 1, 4'b0111, 4'b0111, 3'd0, 14'h0000, 4'd9);
    set_vec(9,  32'hB2F80003, 3, 1, 1, 4'b0010, 4'b0111, 3'd0, 14'h0000, 4'd10);
    set_vec(10, 32'h71000400, 1, 1, 1, 4'b0001, 4'b0001, 3'd0, 14'h0400, 4'd11);
    set_vec(11, 32'h97000002, 2, 1, 0, 4'b0111, 4'b0111, 3'd0, 14'h0000, 4'd12);
    set_vec(12, 32'h30073FFF, 1, 1, 1, 4'b0000, 4'b0000, 3'd7, 14'h3FFF, 4'd13);
    set_vec(13, 32'hF5000001, 1, 1, 1, 4'b0101, 4'b0101, 3'd0, 14'h0000, 4'd14);
    set_vec(14, 32'hB7000006, 6, 1, 1, 4'b0111, 4'b0111, 3'd0, 14'h0000, 4'd15);
    set_vec(15, 32'h36000400, 1, 1, 1, 4'b0110, 4'b0110, 3'd0, 14'h0400, 4'd15);
    for (int i = 0; i < NUM_ENTRIES; i++) rom[i] = vt[i].word;

    reset_pins = pack(1'b0, 1'b0, 4'b1111, 3'd0, 14'h0, 4'd0, 1'b0);
    done_pins  = pack(1'b1, 1'b1, 4'b0111, 3'd0, 14'h0, 4'd15, 1'b1);

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_values", actual(), reset_pins);

    rst_n = 1'b1;
    @(posedge clk); #1;
    check("fetch_no_pin_change", actual(), reset_pins);
    @(posedge clk); #1;

    for (int i = 0; i < NUM_ENTRIES; i++) begin
      for (int c = 0; c < vt[i].occ; c++) begin
        check($sformatf("entry%0d_cyc%0d", i, c), actual(),
              pack(vt[i].rn, vt[i].ck, (c == 0) ? vt[i].cmd_first : vt[i].cmd_rest,
                   vt[i].ba, vt[i].addr, vt[i].raddr, 1'b0));
        @(posedge clk); #1;
      end
    end
    check("done_entry", actual(), done_pins);

    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      check($sformatf("done_hold_%0d", k), actual(), done_pins);
    end

    // Long entry 2 (D=100): 2 + (5+3+100+1+1+4+4+1+1+3+1+2+1+1+6+1) = 137 edges to done.
    rom[2] = 32'hB7000064;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("reset_from_done", actual(), reset_pins);
    rst_n = 1'b1;
    cycles_to_done(lat);
    check_int("first_run_latency", lat, 137);

    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    check("mid_entry2", actual(), pack(1'b1, 1'b1, 4'b0111, 3'd0, 14'h0, 4'd3, 1'b0));
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_reset_values", actual(), reset_pins);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_reset_fetch", actual(), reset_pins);
    cycles_to_done(lat);
    check_int("replay_latency", lat + 1, 137);
    check("replay_done_pins", actual(), done_pins);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
